imem_boot_loader: RTL and testbench

Boot-time controller that fills the 64-word instruction memory of the single-cycle RISC-V core from a byte stream and holds the core in reset until a complete, checksum-verified program is in place. Sits between an external byte source (UART receiver or test harness) and the instruction memory's write port. Drives the core-hold line released to the processor once loading succeeds.

---
 rtl/imem_boot_loader.sv | 124 ++++++++++++
 tb/tb_imem_boot_loader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader: fills the instruction memory from a count/payload/checksum byte stream
// and keeps the core in reset until a complete, verified program is loaded.
module imem_boot_loader #(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          in_ready,
   output logic          we,
   output logic [AW-1:0] waddr,
   output logic [31:0]   wdata,
   output logic          core_hold,
   output logic          done,
   output logic          error
);

   // Handshake: a byte moves on a rising edge where in_valid && in_ready are both 1;
   // in_ready is a register and never depends on in_valid in the same cycle.
   typedef enum logic [2:0] {
      S_IDLE,
      S_COUNT,
      S_DATA,
      S_CHECK,
      S_DONE,
      S_ERR
   } state_t;

   state_t      state;
   logic [AW:0] word_cnt;
   logic [AW:0] word_idx;
   logic [1:0]  byte_idx;
   logic [23:0] asm_q;
   logic [7:0]  csum;
   logic        xfer;

   assign xfer = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         in_ready  <= 1'b0;
         we        <= 1'b0;
         waddr     <= '0;
         wdata     <= '0;
         core_hold <= 1'b1;
         done      <= 1'b0;
         error     <= 1'b0;
         word_cnt  <= '0;
         word_idx  <= '0;
         byte_idx  <= '0;
         asm_q     <= '0;
         csum      <= '0;
      end else begin
         we <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  state     <= S_COUNT;
                  in_ready  <= 1'b1;
                  core_hold <= 1'b1;
                  done      <= 1'b0;
                  error     <= 1'b0;
               end
            end
            S_COUNT: begin
               if (xfer) begin
                  if (in_data == 8'd0 || int'(in_data) > DEPTH) begin
                     state    <= S_ERR;
                     in_ready <= 1'b0;
                     error    <= 1'b1;
                  end else begin
                     state    <= S_DATA;
                     word_cnt <= in_data[AW:0];
                     word_idx <= '0;
                     byte_idx <= '0;
                     csum     <= '0;
                  end
               end
            end
            S_DATA: begin
               if (xfer) begin
                  csum <= csum ^ in_data;
                  // The top lane arrives last, so the write uses it directly from in_data.
                  if (byte_idx == 2'd3) begin
                     we       <= 1'b1;
                     waddr    <= word_idx[AW-1:0];
                     wdata    <= {in_data, asm_q};
                     byte_idx <= '0;
                     word_idx <= word_idx + {{AW{1'b0}}, 1'b1};
                     if (word_idx + {{AW{1'b0}}, 1'b1} == word_cnt) begin
                        state <= S_CHECK;
                     end
                  end else begin
                     asm_q[8*byte_idx +: 8] <= in_data;
                     byte_idx               <= byte_idx + 2'd1;
                  end
               end
            end
            S_CHECK: begin
               if (xfer) begin
                  in_ready <= 1'b0;
                  if (in_data == csum) begin
                     state     <= S_DONE;
                     done      <= 1'b1;
                     core_hold <= 1'b0;
                  end else begin
                     state <= S_ERR;
                     error <= 1'b1;
                  end
               end
            end
            default: begin
               state    <= S_IDLE;
               in_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: random programs streamed with random gaps,
// expected writes and status derived from the stream format.
module tb_imem_boot_loader;
   localparam int DEPTH = 64;
   localparam int AW    = 6;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic          we;
   logic [AW-1:0] waddr;
   logic [31:0]   wdata;
   logic          core_hold;
   logic          done;
   logic          error;

   int vectors     = 0;
   int miscompares = 0;
   logic [AW+31:0] exp_q[$];
   logic [31:0]    prog[DEPTH];

   imem_boot_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .we(we), .waddr(waddr), .wdata(wdata),
      .core_hold(core_hold), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Every write pulse must match the next expected (address, word) pair.
   always @(negedge clk) begin
      if (we === 1'b1) begin
         check("we_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) check("write", 64'({waddr, wdata}), 64'(exp_q.pop_front()));
      end
   end

   task automatic send_byte(input logic [7:0] b, input int max_gap, input bit expect_we);
      int waited = 0;
      int gap = $urandom_range(max_gap, 0);
      for (int i = 0; i < gap; i++) begin
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      check("handshake_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      check("we_after_byte", 64'(we), 64'(expect_we));
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("start_in_ready", 64'(in_ready), 64'd1);
      check("start_core_hold", 64'(core_hold), 64'd1);
      check("start_done", 64'(done), 64'd0);
      check("start_error", 64'(error), 64'd0);
   endtask

   task automatic load_program(input int n, input int max_gap, input bit bad);
      logic [7:0] cs = 8'h00;
      logic [7:0] b;
      send_byte(8'(n), max_gap, 1'b0);
      for (int w = 0; w < n; w++) begin
         exp_q.push_back({AW'(w), prog[w]});
         for (int k = 0; k < 4; k++) begin
            b  = prog[w][8*k +: 8];
            cs = cs ^ b;
            send_byte(b, max_gap, k == 3);
         end
      end
      send_byte(bad ? (cs ^ 8'h5A) : cs, max_gap, 1'b0);
      check("end_done", 64'(done), 64'(!bad));
      check("end_error", 64'(error), 64'(bad));
      check("end_core_hold", 64'(core_hold), 64'(bad));
      check("end_in_ready", 64'(in_ready), 64'd0);
      check("writes_left", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic bad_count(input logic [7:0] n);
      pulse_start();
      send_byte(n, 0, 1'b0);
      check("badcnt_error", 64'(error), 64'd1);
      check("badcnt_in_ready", 64'(in_ready), 64'd0);
      check("badcnt_core_hold", 64'(core_hold), 64'd1);
      check("badcnt_done", 64'(done), 64'd0);
   endtask

   task automatic random_prog();
      for (int i = 0; i < DEPTH; i++) prog[i] = $urandom;
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'hAB;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_we", 64'(we), 64'd0);
      check("rst_waddr", 64'(waddr), 64'd0);
      check("rst_wdata", 64'(wdata), 64'd0);
      check("rst_core_hold", 64'(core_hold), 64'd1);
      check("rst_done", 64'(done), 64'd0);
      check("rst_error", 64'(error), 64'd0);
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("idle_in_ready", 64'(in_ready), 64'd0);
      check("idle_core_hold", 64'(core_hold), 64'd1);
      in_valid = 1'b0;

      // Nominal two-word program
      prog[0] = 32'h00500113;
      prog[1] = 32'h00C00193;
      pulse_start();
      load_program(2, 0, 1'b0);

      // Bad checksum, then a clean reload from ERR
      pulse_start();
      load_program(2, 0, 1'b1);
      pulse_start();
      load_program(2, 1, 1'b0);

      // Illegal counts
      bad_count(8'h00);
      bad_count(8'h41);

      // Smallest legal program
      random_prog();
      pulse_start();
      load_program(1, 2, 1'b0);

      // Full depth with random gaps
      random_prog();
      pulse_start();
      load_program(DEPTH, 3, 1'b0);

      // Reset after two bytes of word 1
      random_prog();
      pulse_start();
      send_byte(8'd2, 0, 1'b0);
      exp_q.push_back({AW'(0), prog[0]});
      for (int k = 0; k < 4; k++) send_byte(prog[0][8*k +: 8], 1, k == 3);
      send_byte(prog[1][7:0], 1, 1'b0);
      send_byte(prog[1][15:8], 1, 1'b0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("midrst_we", 64'(we), 64'd0);
      check("midrst_waddr", 64'(waddr), 64'd0);
      check("midrst_wdata", 64'(wdata), 64'd0);
      check("midrst_in_ready", 64'(in_ready), 64'd0);
      check("midrst_core_hold", 64'(core_hold), 64'd1);
      repeat (4) @(posedge clk);
      #1;
      check("midrst_no_writes", 64'(exp_q.size()), 64'd0);
      pulse_start();
      load_program(3, 1, 1'b0);

      // Random programs of random length, some with corrupted checksums
      for (int t = 0; t < 6; t++) begin
         random_prog();
         pulse_start();
         load_program($urandom_range(16, 1), 2, ($urandom_range(3, 0) == 0));
      end

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
